// File: rtl/mc_control_unit.sv
// -----------------------------------------------------------------------------
// mc_control_unit
//
// Multi-cycle control FSM for the MIPS subset (R-type, lw, sw, beq, addi, j).
// Sequences the shared instruction/data memory through a level ready
// handshake, traps on a memory access that waits too long or on an unknown
// opcode, and counts retired instructions.
//
// Parameters
//   MEM_TIMEOUT  : wait cycles tolerated per memory access (0 = no limit)
//   ILLEGAL_TRAP : 1 = unknown opcode traps, 0 = retired as a NOP
//   CNT_W        : width of the retired-instruction counter
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   opcode       : IR[31:26]
//   mem_ready    : memory completes the current access this cycle
//   PCWrite .. ALUSrcA, PCSrc, ALUOp, ALUSrcB : datapath controls
//   trap         : sticky trap flag
//   trap_cause   : 01 illegal opcode, 10 memory timeout
//   state        : current state (debug)
//   retired      : completed-instruction count, wraps
// -----------------------------------------------------------------------------
module mc_control_unit #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int ILLEGAL_TRAP = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       PCSrc,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Counter only has to hold values 0..MEM_TIMEOUT; +2 keeps WAIT_W >= 1.
    localparam int              WAIT_W     = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic            TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic            TRAP_EN    = (ILLEGAL_TRAP != 0);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               trap_q, trap_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire_s;
    logic               ready_s;
    logic               timed_out_s;

    // While reset is held the Mealy strobes must not follow mem_ready.
    assign ready_s     = mem_ready & rst;
    // Ready in the same cycle wins over the timeout.
    assign timed_out_s = TIMEOUT_EN && (wait_q == WAIT_LIMIT) && !ready_s;

    // Next-state, wait counter, trap capture and retire strobe.
    always_comb begin
        state_d  = state_q;
        wait_d   = '0;        // any state change clears the wait count
        trap_d   = trap_q;
        cause_d  = cause_q;
        retire_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (ready_s) begin
                    state_d = S_DECODE;
                end else if (timed_out_s) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        if (TRAP_EN) begin
                            state_d = S_TRAP;
                            trap_d  = 1'b1;
                            cause_d = CAUSE_ILLEGAL;
                        end else begin
                            state_d  = S_FETCH;
                            retire_s = 1'b1;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (ready_s) begin
                    state_d = S_MEMWB;
                end else if (timed_out_s) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_MEMWB: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_MEMWR: begin
                if (ready_s) begin
                    state_d  = S_FETCH;
                    retire_s = 1'b1;
                end else if (timed_out_s) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_BRANCH: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_JUMP: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_TRAP:   state_d = S_TRAP;   // only reset leaves TRAP
            default:  state_d = S_FETCH;  // unused codes 12..14
        endcase

        if (retire_s) begin
            retired_d = retired_q + CNT_W'(1);
        end else begin
            retired_d = retired_q;
        end
    end

    // Datapath control decode from the current state.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        PCSrc       = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = ready_s;
                PCWrite = ready_s;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSrc       = 2'b01;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
            end
            default: PCWrite = 1'b0;      // TRAP and unused codes: all idle
        endcase
    end

    // State, wait counter, trap status and retire counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    assign state      = state_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// -----------------------------------------------------------------------------
// Directed bench for mc_control_unit. Two instances share one set of inputs:
//   dut_a : MEM_TIMEOUT=4,  ILLEGAL_TRAP=1, CNT_W=32
//   dut_b : MEM_TIMEOUT=16, ILLEGAL_TRAP=0, CNT_W=4
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_mc_control_unit;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic [5:0] opcode    = 6'd0;
    logic       mem_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic        a_PCWrite, a_PCWriteCond, a_IorD, a_MemRead, a_MemWrite;
    logic        a_IRWrite, a_MemtoReg, a_RegWrite, a_RegDst, a_ALUSrcA;
    logic [1:0]  a_PCSrc, a_ALUOp, a_ALUSrcB, a_trap_cause;
    logic        a_trap;
    logic [3:0]  a_state;
    logic [31:0] a_retired;

    logic        b_PCWrite, b_PCWriteCond, b_IorD, b_MemRead, b_MemWrite;
    logic        b_IRWrite, b_MemtoReg, b_RegWrite, b_RegDst, b_ALUSrcA;
    logic [1:0]  b_PCSrc, b_ALUOp, b_ALUSrcB, b_trap_cause;
    logic        b_trap;
    logic [3:0]  b_state;
    logic [3:0]  b_retired;

    always #5 clk = ~clk;

    mc_control_unit #(.MEM_TIMEOUT(4), .ILLEGAL_TRAP(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(a_PCWrite), .PCWriteCond(a_PCWriteCond), .IorD(a_IorD),
        .MemRead(a_MemRead), .MemWrite(a_MemWrite), .IRWrite(a_IRWrite),
        .MemtoReg(a_MemtoReg), .RegWrite(a_RegWrite), .RegDst(a_RegDst),
        .ALUSrcA(a_ALUSrcA), .PCSrc(a_PCSrc), .ALUOp(a_ALUOp), .ALUSrcB(a_ALUSrcB),
        .trap(a_trap), .trap_cause(a_trap_cause), .state(a_state), .retired(a_retired)
    );

    mc_control_unit #(.MEM_TIMEOUT(16), .ILLEGAL_TRAP(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .IorD(b_IorD),
        .MemRead(b_MemRead), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite),
        .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite), .RegDst(b_RegDst),
        .ALUSrcA(b_ALUSrcA), .PCSrc(b_PCSrc), .ALUOp(b_ALUOp), .ALUSrcB(b_ALUSrcB),
        .trap(b_trap), .trap_cause(b_trap_cause), .state(b_state), .retired(b_retired)
    );

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b0;
        opcode    = 6'd0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        rst       = 1'b0;
        mem_ready = 1'b1;
        #2;
        n_vec++;
        if ({a_state, a_trap, a_trap_cause} !== 7'b0000_0_00) begin
            n_err++;
            $display("FAIL reset_status got state=%0d trap=%b cause=%b exp 0/0/00", a_state, a_trap, a_trap_cause);
        end
        n_vec++;
        if (a_retired !== 32'd0 || b_retired !== 4'd0) begin
            n_err++;
            $display("FAIL reset_retired got a=%0d b=%0d exp 0/0", a_retired, b_retired);
        end
        n_vec++;
        if ({a_MemRead, a_IRWrite, a_PCWrite, a_MemWrite, a_RegWrite, a_PCWriteCond, a_IorD, a_ALUSrcB}
            !== 9'b1_000000_01) begin
            n_err++;
            $display("FAIL reset_ctrl got %b exp 100000001",
                     {a_MemRead, a_IRWrite, a_PCWrite, a_MemWrite, a_RegWrite, a_PCWriteCond, a_IorD, a_ALUSrcB});
        end
    endtask

    task automatic test_rtype();
        logic [3:0] seq  [5];
        logic [1:0] srcb [5];
        seq  = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        srcb = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b01};
        do_reset();
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if (a_state !== seq[i]) begin
                n_err++;
                $display("FAIL rtype_state[%0d] got %0d exp %0d", i, a_state, seq[i]);
            end
            n_vec++;
            if ({a_RegWrite, a_RegDst, a_IRWrite, a_ALUSrcB} !== {seq[i] == 4'd7, seq[i] == 4'd7, seq[i] == 4'd0, srcb[i]}) begin
                n_err++;
                $display("FAIL rtype_ctrl[%0d] got %b exp %b", i, {a_RegWrite, a_RegDst, a_IRWrite, a_ALUSrcB},
                         {seq[i] == 4'd7, seq[i] == 4'd7, seq[i] == 4'd0, srcb[i]});
            end
            if (i < 4) @(negedge clk);
        end
        n_vec++;
        if (a_retired !== 32'd1) begin
            n_err++;
            $display("FAIL rtype_retired got %0d exp 1", a_retired);
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0] seq [9];
        logic       rdy [9];
        seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        opcode = 6'b100011;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy[i];
            #1;
            n_vec++;
            if (a_state !== seq[i]) begin
                n_err++;
                $display("FAIL lw_state[%0d] got %0d exp %0d", i, a_state, seq[i]);
            end
            n_vec++;
            if ({a_MemRead, a_IorD, a_RegWrite, a_MemtoReg} !==
                {seq[i] == 4'd3 || seq[i] == 4'd0, seq[i] == 4'd3, seq[i] == 4'd4, seq[i] == 4'd4}) begin
                n_err++;
                $display("FAIL lw_ctrl[%0d] got %b exp %b", i, {a_MemRead, a_IorD, a_RegWrite, a_MemtoReg},
                         {seq[i] == 4'd3 || seq[i] == 4'd0, seq[i] == 4'd3, seq[i] == 4'd4, seq[i] == 4'd4});
            end
            if (i < 8) @(negedge clk);
        end
        n_vec++;
        if (a_retired !== 32'd1 || a_trap !== 1'b0) begin
            n_err++;
            $display("FAIL lw_retired got %0d trap=%b exp 1 trap=0", a_retired, a_trap);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        opcode    = 6'b000000;
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if ({a_state, a_trap} !== 5'b0000_0) begin
                n_err++;
                $display("FAIL timeout_wait[%0d] got state=%0d trap=%b exp 0/0", i, a_state, a_trap);
            end
            @(negedge clk);
        end
        #1;
        n_vec++;
        if ({a_state, a_trap, a_trap_cause} !== 7'b1111_1_10) begin
            n_err++;
            $display("FAIL timeout_trap got state=%0d trap=%b cause=%b exp 15/1/10", a_state, a_trap, a_trap_cause);
        end
        n_vec++;
        if ({b_state, b_trap} !== 5'b0000_0) begin
            n_err++;
            $display("FAIL timeout_long got state=%0d trap=%b exp 0/0", b_state, b_trap);
        end
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({a_state, a_trap, a_MemRead, a_IRWrite, a_PCWrite, a_ALUSrcB} !== 10'b1111_1_000_00) begin
            n_err++;
            $display("FAIL trap_sticky got state=%0d trap=%b ctrl=%b exp 15/1/00000", a_state, a_trap,
                     {a_MemRead, a_IRWrite, a_PCWrite, a_ALUSrcB});
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({a_state, a_trap, a_trap_cause} !== 7'b0000_0_00) begin
            n_err++;
            $display("FAIL trap_clear got state=%0d trap=%b cause=%b exp 0/0/00", a_state, a_trap, a_trap_cause);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        opcode    = 6'b111111;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if (a_state !== 4'd1) begin
            n_err++;
            $display("FAIL illegal_decode got %0d exp 1", a_state);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if ({a_state, a_trap, a_trap_cause} !== 7'b1111_1_01 || a_retired !== 32'd0) begin
            n_err++;
            $display("FAIL illegal_trap got state=%0d trap=%b cause=%b ret=%0d exp 15/1/01/0",
                     a_state, a_trap, a_trap_cause, a_retired);
        end
        n_vec++;
        if ({b_state, b_trap, b_retired} !== 9'b0000_0_0001) begin
            n_err++;
            $display("FAIL illegal_nop got state=%0d trap=%b ret=%0d exp 0/0/1", b_state, b_trap, b_retired);
        end
    endtask

    task automatic test_sw();
        logic [3:0] seq [5];
        seq = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        do_reset();
        opcode    = 6'b101011;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if ({a_state, a_MemWrite, a_IorD} !== {seq[i], seq[i] == 4'd5, seq[i] == 4'd5}) begin
                n_err++;
                $display("FAIL sw_step[%0d] got state=%0d we=%b iord=%b exp state=%0d", i, a_state,
                         a_MemWrite, a_IorD, seq[i]);
            end
            if (i < 4) @(negedge clk);
        end
        n_vec++;
        if (a_retired !== 32'd1) begin
            n_err++;
            $display("FAIL sw_retired got %0d exp 1", a_retired);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        opcode    = 6'b101011;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({a_state, a_MemWrite} !== 5'b0101_1) begin
            n_err++;
            $display("FAIL memwr_hold got state=%0d we=%b exp 5/1", a_state, a_MemWrite);
        end
        #1;
        rst       = 1'b0;
        mem_ready = 1'b1;
        #1;
        n_vec++;
        if ({a_state, a_MemWrite, a_IorD, a_MemRead, a_IRWrite, a_PCWrite} !== 9'b0000_0_0_1_0_0) begin
            n_err++;
            $display("FAIL async_abort got state=%0d ctrl=%b exp 0/00100", a_state,
                     {a_MemWrite, a_IorD, a_MemRead, a_IRWrite, a_PCWrite});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_addi_beq();
        do_reset();
        opcode    = 6'b001000;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({a_state, a_ALUSrcA, a_ALUSrcB, a_ALUOp} !== 9'b1001_1_10_00) begin
            n_err++;
            $display("FAIL addi_ex got state=%0d srca=%b srcb=%b op=%b exp 9/1/10/00", a_state, a_ALUSrcA,
                     a_ALUSrcB, a_ALUOp);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if ({a_state, a_RegWrite, a_RegDst, a_MemtoReg} !== 7'b1010_1_0_0) begin
            n_err++;
            $display("FAIL addi_wb got state=%0d rw=%b dst=%b m2r=%b exp 10/1/0/0", a_state, a_RegWrite,
                     a_RegDst, a_MemtoReg);
        end
        do_reset();
        opcode    = 6'b000100;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({a_state, a_PCWriteCond, a_PCSrc, a_ALUOp, a_ALUSrcA, a_PCWrite} !== 11'b1000_1_01_01_1_0) begin
            n_err++;
            $display("FAIL beq got state=%0d ctrl=%b exp 8/1010110", a_state,
                     {a_PCWriteCond, a_PCSrc, a_ALUOp, a_ALUSrcA, a_PCWrite});
        end
        @(negedge clk);
        #1;
        n_vec++;
        if ({a_state, a_retired} !== {4'd0, 32'd1}) begin
            n_err++;
            $display("FAIL beq_done got state=%0d ret=%0d exp 0/1", a_state, a_retired);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_state;
        do_reset();
        opcode    = 6'b000010;
        mem_ready = 1'b1;
        for (int i = 0; i < 51; i++) begin
            #1;
            exp_state = (i % 3 == 0) ? 4'd0 : ((i % 3 == 1) ? 4'd1 : 4'd11);
            n_vec++;
            if (a_state !== exp_state) begin
                n_err++;
                $display("FAIL jmp_state[%0d] got %0d exp %0d", i, a_state, exp_state);
            end
            if (exp_state == 4'd11) begin
                n_vec++;
                if ({a_PCWrite, a_PCSrc} !== 3'b1_10) begin
                    n_err++;
                    $display("FAIL jmp_ctrl[%0d] got %b exp 110", i, {a_PCWrite, a_PCSrc});
                end
            end
            if (i == 48) begin
                n_vec++;
                if (a_retired !== 32'd16 || b_retired !== 4'd0) begin
                    n_err++;
                    $display("FAIL jmp_wrap16 got a=%0d b=%0d exp 16/0", a_retired, b_retired);
                end
            end
            @(negedge clk);
        end
        #1;
        n_vec++;
        if (a_retired !== 32'd17 || b_retired !== 4'd1) begin
            n_err++;
            $display("FAIL jmp_retired got a=%0d b=%0d exp 17/1", a_retired, b_retired);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_timeout();
        test_illegal();
        test_sw();
        test_reset_mid_write();
        test_addi_beq();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
